// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
package wb_arb_pkg;

    localparam int REG_ADDR_W     = 5;
    localparam int XLEN           = 32;
    localparam int DEPTH_DEF      = 2;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [0:0] {
        S_NORM  = 1'b0,
        S_DRAIN = 1'b1
    } state_e;

endpackage

// File: rtl/wb_arb_fifo.sv
// Small synchronous FIFO buffering long-latency results; DEPTH must be a power of two.
module wb_arb_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W     = REG_ADDR_W + XLEN
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + PW'(1);
            if (pop_i)  rptr_q <= rptr_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline write-back vs. buffered long-latency results.
// Define WB_ARB_STARVE_EN to enable the starvation counter and the one-cycle S_DRAIN stall.
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pipe_we_i,
    input  logic [REG_ADDR_W-1:0]    pipe_waddr_i,
    input  logic [XLEN-1:0]          pipe_wdata_i,
    input  logic                     lu_valid_i,
    output logic                     lu_ready_o,
    input  logic [REG_ADDR_W-1:0]    lu_waddr_i,
    input  logic [XLEN-1:0]          lu_wdata_i,
    output logic                     pipe_stall_o,
    output logic                     rf_we_o,
    output logic [REG_ADDR_W-1:0]    rf_waddr_o,
    output logic [XLEN-1:0]          rf_wdata_o,
    output logic [$clog2(DEPTH):0]   buf_count_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = REG_ADDR_W + XLEN;

    logic                  pipe_req, lu_push, fifo_pop, fifo_nempty, drain;
    logic [ENT_W-1:0]      fifo_head;
    logic                  sel_we;
    logic [REG_ADDR_W-1:0] sel_waddr;
    logic [XLEN-1:0]       sel_wdata;
    logic                  rf_we_q;
    logic [REG_ADDR_W-1:0] rf_waddr_q;
    logic [XLEN-1:0]       rf_wdata_q;

    // Writes to x0 are dropped at the boundary; lu x0 results still complete the handshake.
    assign pipe_req    = pipe_we_i && (pipe_waddr_i != '0);
    assign lu_ready_o  = (buf_count_o < CNT_W'(DEPTH));
    assign lu_push     = lu_valid_i && lu_ready_o && (lu_waddr_i != '0);
    assign fifo_nempty = (buf_count_o != '0);

    wb_arb_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (lu_push),
        .pop_i   (fifo_pop),
        .wdata_i ({lu_waddr_i, lu_wdata_i}),
        .rdata_o (fifo_head),
        .count_o (buf_count_o)
    );

`ifdef WB_ARB_STARVE_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_e     state_q, state_d;
    logic [3:0] starve_q, starve_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_NORM;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // S_DRAIN always lasts one cycle and returns with the counter cleared.
    always_comb begin
        state_d  = S_NORM;
        starve_d = '0;
        if (state_q == S_NORM && fifo_nempty && !fifo_pop) begin
            if (starve_q + 4'd1 == STARVE_LIM) state_d  = S_DRAIN;
            else                               starve_d = starve_q + 4'd1;
        end
    end

    assign drain = (state_q == S_DRAIN);
`else
    logic unused_starve;
    assign unused_starve = ^STARVE_MAX;
    assign drain         = 1'b0;
`endif

    assign pipe_stall_o = drain;

    always_comb begin
        fifo_pop  = 1'b0;
        sel_we    = 1'b0;
        sel_waddr = '0;
        sel_wdata = '0;
        if (pipe_req && !drain) begin
            sel_we    = 1'b1;
            sel_waddr = pipe_waddr_i;
            sel_wdata = pipe_wdata_i;
        end else if (fifo_nempty) begin
            fifo_pop               = 1'b1;
            sel_we                 = 1'b1;
            {sel_waddr, sel_wdata} = fifo_head;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q    <= sel_we;
            rf_waddr_q <= sel_waddr;
            rf_wdata_q <= sel_wdata;
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter (DEPTH=2, STARVE_MAX=4); rf writes checked against a scoreboard.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_we = 1'b0;
    logic [4:0]  pipe_waddr = '0;
    logic [31:0] pipe_wdata = '0;
    logic        lu_valid = 1'b0;
    logic [4:0]  lu_waddr = '0;
    logic [31:0] lu_wdata = '0;
    logic        lu_ready_o, pipe_stall_o, rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [1:0]  buf_count_o;

    int          checks = 0;
    int          errors = 0;
    logic [36:0] exp_q[$];
    logic [36:0] exp_w;

    wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pipe_we_i    (pipe_we),
        .pipe_waddr_i (pipe_waddr),
        .pipe_wdata_i (pipe_wdata),
        .lu_valid_i   (lu_valid),
        .lu_ready_o   (lu_ready_o),
        .lu_waddr_i   (lu_waddr),
        .lu_wdata_i   (lu_wdata),
        .pipe_stall_o (pipe_stall_o),
        .rf_we_o      (rf_we_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o),
        .buf_count_o  (buf_count_o)
    );

    initial forever #5 clk = ~clk;

    // Every register-file write must match the next expected write, in order.
    always @(negedge clk) begin
        if (rst_n && rf_we_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got x%0d=%h, no write expected", rf_waddr_o, rf_wdata_o);
            end else begin
                exp_w = exp_q.pop_front();
                if ({rf_waddr_o, rf_wdata_o} !== exp_w) begin
                    errors++;
                    $display("FAIL sb_write: got x%0d=%h want x%0d=%h",
                             rf_waddr_o, rf_wdata_o, exp_w[36:32], exp_w[31:0]);
                end
            end
        end
    end

    task automatic test_reset();
        #2;
        checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %b want 0", rf_we_o); end
        checks++; if (rf_waddr_o !== 5'd0) begin errors++; $display("FAIL reset_rf_waddr: got %0d want 0", rf_waddr_o); end
        checks++; if (rf_wdata_o !== 32'd0) begin errors++; $display("FAIL reset_rf_wdata: got %h want 0", rf_wdata_o); end
        checks++; if (pipe_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", pipe_stall_o); end
        checks++; if (buf_count_o !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", buf_count_o); end
        checks++; if (lu_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", lu_ready_o); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_pipe_only();
        for (int i = 0; i < 4; i++) begin
            pipe_we = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'h1234;
            exp_q.push_back({5'd5, 32'h1234});
            @(negedge clk);
            checks++; if (rf_we_o !== 1'b1) begin errors++; $display("FAIL pipe_latency: got we=%b want 1", rf_we_o); end
            checks++; if (pipe_stall_o !== 1'b0) begin errors++; $display("FAIL pipe_stall: got %b want 0", pipe_stall_o); end
        end
        pipe_we = 1'b0;
        @(negedge clk);
        checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL pipe_idle: got we=%b want 0", rf_we_o); end
    endtask

    task automatic test_idle_drain();
        lu_valid = 1'b1; lu_waddr = 5'd7; lu_wdata = 32'hDEAD;
        checks++; if (lu_ready_o !== 1'b1) begin errors++; $display("FAIL drain_ready: got %b want 1", lu_ready_o); end
        exp_q.push_back({5'd7, 32'hDEAD});
        @(negedge clk);
        lu_valid = 1'b0;
        checks++; if (buf_count_o !== 2'd1) begin errors++; $display("FAIL drain_count1: got %0d want 1", buf_count_o); end
        checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL drain_early: got we=%b want 0", rf_we_o); end
        @(negedge clk);
        checks++; if (rf_we_o !== 1'b1) begin errors++; $display("FAIL drain_write: got we=%b want 1", rf_we_o); end
        checks++; if (buf_count_o !== 2'd0) begin errors++; $display("FAIL drain_count0: got %0d want 0", buf_count_o); end
        @(negedge clk);
        checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL drain_after: got we=%b want 0", rf_we_o); end
    endtask

    task automatic test_back_pressure();
        pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h100;
        lu_valid = 1'b1; lu_waddr = 5'd10; lu_wdata = 32'hA000_0000;
        exp_q.push_back({5'd3, 32'h100});
        @(negedge clk);
        checks++; if (buf_count_o !== 2'd1) begin errors++; $display("FAIL bp_count1: got %0d want 1", buf_count_o); end
        checks++; if (lu_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b want 1", lu_ready_o); end
        pipe_wdata = 32'h101; lu_waddr = 5'd11; lu_wdata = 32'hA000_0001;
        exp_q.push_back({5'd3, 32'h101});
        @(negedge clk);
        checks++; if (buf_count_o !== 2'd2) begin errors++; $display("FAIL bp_count2: got %0d want 2", buf_count_o); end
        checks++; if (lu_ready_o !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b want 0", lu_ready_o); end
        pipe_wdata = 32'h102; lu_waddr = 5'd12; lu_wdata = 32'hA000_0002;
        exp_q.push_back({5'd3, 32'h102});
        @(negedge clk);
        checks++; if (buf_count_o !== 2'd2) begin errors++; $display("FAIL bp_held_count: got %0d want 2", buf_count_o); end
        checks++; if (pipe_stall_o !== 1'b0) begin errors++; $display("FAIL bp_stall: got %b want 0", pipe_stall_o); end
        pipe_we = 1'b0;
        exp_q.push_back({5'd10, 32'hA000_0000});
        @(negedge clk);
        checks++; if (buf_count_o !== 2'd1) begin errors++; $display("FAIL bp_pop_count: got %0d want 1", buf_count_o); end
        checks++; if (lu_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_again: got %b want 1", lu_ready_o); end
        exp_q.push_back({5'd11, 32'hA000_0001});
        @(negedge clk);
        checks++; if (buf_count_o !== 2'd1) begin errors++; $display("FAIL bp_pushpop_count: got %0d want 1", buf_count_o); end
        lu_valid = 1'b0;
        exp_q.push_back({5'd12, 32'hA000_0002});
        @(negedge clk);
        checks++; if (buf_count_o !== 2'd0) begin errors++; $display("FAIL bp_empty: got %0d want 0", buf_count_o); end
        @(negedge clk);
    endtask

    task automatic test_x0();
        pipe_we = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'h55;
        lu_valid = 1'b1; lu_waddr = 5'd0; lu_wdata = 32'h66;
        @(negedge clk);
        checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL x0_write: got we=%b want 0", rf_we_o); end
        checks++; if (buf_count_o !== 2'd0) begin errors++; $display("FAIL x0_count: got %0d want 0", buf_count_o); end
        pipe_we = 1'b0; lu_valid = 1'b0;
        @(negedge clk);
        checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL x0_after: got we=%b want 0", rf_we_o); end
        checks++; if (buf_count_o !== 2'd0) begin errors++; $display("FAIL x0_count2: got %0d want 0", buf_count_o); end
    endtask

`ifdef WB_ARB_STARVE_EN
    task automatic test_starvation();
        lu_valid = 1'b1; lu_waddr = 5'd15; lu_wdata = 32'hC0C0_C0C0;
        pipe_we = 1'b1; pipe_waddr = 5'd6;
        for (int i = 0; i < 5; i++) begin
            pipe_wdata = 32'h600 + 32'(i);
            exp_q.push_back({5'd6, 32'h600 + 32'(i)});
            @(negedge clk);
            lu_valid = 1'b0;
            checks++;
            if (pipe_stall_o !== (i == 4)) begin
                errors++; $display("FAIL starve_stall: cycle %0d got %b want %b", i + 1, pipe_stall_o, (i == 4));
            end
        end
        pipe_wdata = 32'h605;
        exp_q.push_back({5'd15, 32'hC0C0_C0C0});
        @(negedge clk);
        checks++; if (pipe_stall_o !== 1'b0) begin errors++; $display("FAIL starve_double: got %b want 0", pipe_stall_o); end
        checks++; if (buf_count_o !== 2'd0) begin errors++; $display("FAIL starve_count: got %0d want 0", buf_count_o); end
        exp_q.push_back({5'd6, 32'h605});
        @(negedge clk);
        checks++; if (rf_we_o !== 1'b1) begin errors++; $display("FAIL starve_replay: got we=%b want 1", rf_we_o); end
        pipe_we = 1'b0;
        @(negedge clk);
    endtask
`else
    task automatic test_strict_priority();
        lu_valid = 1'b1; lu_waddr = 5'd15; lu_wdata = 32'hC0C0_C0C0;
        pipe_we = 1'b1; pipe_waddr = 5'd6;
        for (int i = 0; i < 7; i++) begin
            pipe_wdata = 32'h600 + 32'(i);
            exp_q.push_back({5'd6, 32'h600 + 32'(i)});
            @(negedge clk);
            lu_valid = 1'b0;
            checks++; if (pipe_stall_o !== 1'b0) begin errors++; $display("FAIL strict_stall: got %b want 0", pipe_stall_o); end
            checks++; if (buf_count_o !== 2'd1) begin errors++; $display("FAIL strict_count: got %0d want 1", buf_count_o); end
        end
        pipe_we = 1'b0;
        exp_q.push_back({5'd15, 32'hC0C0_C0C0});
        @(negedge clk);
        checks++; if (buf_count_o !== 2'd0) begin errors++; $display("FAIL strict_drain: got %0d want 0", buf_count_o); end
        @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid();
        pipe_we = 1'b1; pipe_waddr = 5'd4; pipe_wdata = 32'h40;
        lu_valid = 1'b1; lu_waddr = 5'd20; lu_wdata = 32'hB000_0000;
        exp_q.push_back({5'd4, 32'h40});
        @(negedge clk);
        pipe_wdata = 32'h41; lu_waddr = 5'd21; lu_wdata = 32'hB000_0001;
        exp_q.push_back({5'd4, 32'h41});
        @(negedge clk);
        checks++; if (buf_count_o !== 2'd2) begin errors++; $display("FAIL rmid_fill: got %0d want 2", buf_count_o); end
        checks++; if (rf_we_o !== 1'b1) begin errors++; $display("FAIL rmid_pending: got we=%b want 1", rf_we_o); end
        pipe_we = 1'b0; lu_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL rmid_we: got %b want 0", rf_we_o); end
        checks++; if (buf_count_o !== 2'd0) begin errors++; $display("FAIL rmid_count: got %0d want 0", buf_count_o); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL rmid_ghost: got we=%b want 0", rf_we_o); end
        end
        checks++; if (buf_count_o !== 2'd0) begin errors++; $display("FAIL rmid_after: got %0d want 0", buf_count_o); end
    endtask

    initial begin
        test_reset();
        test_pipe_only();
        test_idle_drain();
        test_back_pressure();
        test_x0();
`ifdef WB_ARB_STARVE_EN
        test_starvation();
`else
        test_strict_priority();
`endif
        test_reset_mid();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d writes never seen, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
